// File: rtl/display_pkg.sv
// Shared types and constants for the display-sharing logic.
// Other shared-peripheral schedulers can reuse the saturation helpers.
package display_pkg;

  localparam int NUM_W = 14;
  localparam int DPN_W = 2;
  localparam logic [NUM_W-1:0] DISP_MAX = 14'd9999;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  // The display driver is decimal-only, so anything above 9999 is pinned there.
  function automatic logic [NUM_W-1:0] saturate(input logic [NUM_W-1:0] value);
    return (value > DISP_MAX) ? DISP_MAX : value;
  endfunction

  function automatic logic isOver(input logic [NUM_W-1:0] value);
    return value > DISP_MAX;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: lowest-index urgent requester wins,
// otherwise the first requester at or after ptr_i, wrapping modulo NUM_SRC.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [NUM_SRC-1:0] urgent_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [NUM_SRC-1:0] winner_o,
  output logic [IDX_W-1:0]   index_o
);

  logic             found;
  logic [IDX_W-1:0] pos;
  int               sum;

  always_comb begin
    found    = 1'b0;
    index_o  = '0;
    winner_o = '0;
    pos      = '0;
    sum      = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pos = IDX_W'(i);
      if (!found && req_i[pos] && urgent_i[pos]) begin
        found   = 1'b1;
        index_o = pos;
      end
    end
    // Round-robin scan; the wrap is an explicit subtract so non-power-of-2 counts work.
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = int'(ptr_i) + k;
      if (sum >= NUM_SRC) sum = sum - NUM_SRC;
      pos = IDX_W'(sum);
      if (!found && req_i[pos]) begin
        found   = 1'b1;
        index_o = pos;
      end
    end
    if (found) winner_o[index_o] = 1'b1;
    valid_o = found;
  end

endmodule

// File: rtl/display_share_scheduler.sv
// Time-slices one 4-digit seven-segment driver among NUM_SRC requesters,
// round-robin with urgent preemption; registered num/dpn follow the owner.
module display_share_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC-1:0]       urgent,
  input  logic [NUM_W*NUM_SRC-1:0] num_in,
  input  logic [DPN_W*NUM_SRC-1:0] dpn_in,
  output logic [NUM_W-1:0]         num,
  output logic [DPN_W-1:0]         dpn,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     switched,
  output logic                     blank,
  output logic                     ovf
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [DPN_W-1:0]   dpn_q, dpn_d;
  logic               ovf_q, ovf_d;
  logic               switched_q, blank_q;

  logic               winValid;
  logic [NUM_SRC-1:0] winOneHot;
  logic [IDX_W-1:0]   winIdx;
  logic               preempt, rearb;

  logic [NUM_W-1:0]   srcNum [NUM_SRC];
  logic [DPN_W-1:0]   srcDpn [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign srcNum[g] = num_in[NUM_W*g +: NUM_W];
    assign srcDpn[g] = dpn_in[DPN_W*g +: DPN_W];
  end

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i    (req),
    .urgent_i (urgent),
    .ptr_i    (ptr_q),
    .valid_o  (winValid),
    .winner_o (winOneHot),
    .index_o  (winIdx)
  );

  // An urgent owner is never preempted; a non-urgent one yields to any other urgent requester.
  assign preempt = (|(req & urgent & ~grant_q)) && !urgent[owner_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    rearb   = 1'b0;
    unique case (state_q)
      S_IDLE: rearb = |req;
      S_HOLD: begin
        if (!req[owner_q] || preempt || count_q == LAST_COUNT) rearb = 1'b1;
        else count_d = count_q + 1'b1;
      end
      default: rearb = 1'b0;
    endcase
    if (rearb) begin
      count_d = '0;
      if (winValid) begin
        state_d = S_HOLD;
        grant_d = winOneHot;
        owner_d = winIdx;
        ptr_d   = (winIdx == IDX_W'(NUM_SRC - 1)) ? '0 : winIdx + 1'b1;
      end else begin
        state_d = S_IDLE;
        grant_d = '0;
        owner_d = '0;
      end
    end
  end

  // Datapath follows the next owner so a new grant and its value appear together.
  always_comb begin
    num_d = '0;
    dpn_d = '0;
    ovf_d = 1'b0;
    if (state_d == S_HOLD) begin
      num_d = saturate(srcNum[owner_d]);
      dpn_d = srcDpn[owner_d];
      ovf_d = isOver(srcNum[owner_d]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      num_q      <= '0;
      dpn_q      <= '0;
      ovf_q      <= 1'b0;
      switched_q <= 1'b0;
      blank_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      num_q      <= num_d;
      dpn_q      <= dpn_d;
      ovf_q      <= ovf_d;
      switched_q <= (grant_d != grant_q);
      blank_q    <= (grant_d == '0);
    end
  end

  assign num      = num_q;
  assign dpn      = dpn_q;
  assign grant    = grant_q;
  assign switched = switched_q;
  assign blank    = blank_q;
  assign ovf      = ovf_q;

endmodule
